// File: rtl/ad_cap_pkg.sv
// Shared types and constants for the ADC I/Q capture path: FSM encodings,
// header magic default and the packed FIFO word layout.
package ad_cap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } cap_state_e;

  localparam int unsigned HALF_W = 16;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 16;

  localparam logic [HALF_W-1:0] HDR_MAGIC_DEF = 16'hA55A;

  typedef struct packed {
    logic              last;
    logic [WORD_W-1:0] data;
  } cap_word_t;

  localparam int unsigned CAP_WORD_W = $bits(cap_word_t);

endpackage

// File: rtl/ad_cap_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with registered full/empty flags.
// Head word is visible on rd_data whenever empty is low.
module ad_cap_sync_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned AW    = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned CW    = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt_c;
  logic             wr_ok_c;
  logic             rd_ok_c;

  // A read frees a slot in the same cycle, so a full FIFO may accept a write alongside it
  always_comb begin
    rd_ok_c   = rd_en & ~empty;
    wr_ok_c   = wr_en & (~full | rd_ok_c);
    cnt_nxt_c = cnt;
    if (wr_ok_c && !rd_ok_c) begin
      cnt_nxt_c = cnt + CW'(1);
    end else if (rd_ok_c && !wr_ok_c) begin
      cnt_nxt_c = cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (wr_ok_c) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok_c) rd_ptr <= rd_ptr + AW'(1);
      cnt   <= cnt_nxt_c;
      full  <= (cnt_nxt_c == FULL_CNT);
      empty <= (cnt_nxt_c == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok_c) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/ad_iq_frame_packer.sv
// DC-offset removal, I/Q word packing and header framing of the ADC sample
// stream, buffered through a FWFT FIFO onto a valid/ready output.
module ad_iq_frame_packer
  import ad_cap_pkg::*;
#(
  parameter int unsigned       DW        = 14,
  parameter int unsigned       FRAME_LEN = 1024,
  parameter int unsigned       FIFO_AW   = 9,
  parameter logic [HALF_W-1:0] HDR_MAGIC = HDR_MAGIC_DEF
) (
  input  logic              adc_clk100m,
  input  logic              ad_rst,
  input  logic [DW-1:0]     ad_data_i,
  input  logic [DW-1:0]     ad_data_q,
  input  logic              ad_data_valid,
  input  logic [DW-1:0]     dc_off_i,
  input  logic [DW-1:0]     dc_off_q,
  input  logic              cap_start,
  input  logic              cont_en,
  output logic [WORD_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_last,
  input  logic              m_ready,
  output logic              busy,
  output logic              overflow,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam int unsigned SCNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [SCNT_W-1:0] LAST_IDX = SCNT_W'(FRAME_LEN - 1);
  localparam int unsigned EXT_W = HALF_W - DW;
  localparam logic [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};

  // Subtract at DW+1 bits; a sign disagreement between the top two bits means overflow
  function automatic logic [DW-1:0] dc_sub(input logic [DW-1:0] x, input logic [DW-1:0] off);
    logic [DW:0] d;
    d = {x[DW-1], x} - {off[DW-1], off};
    if (d[DW] != d[DW-1]) begin
      return d[DW] ? SAT_MIN : SAT_MAX;
    end
    return d[DW-1:0];
  endfunction

  function automatic logic [HALF_W-1:0] sext16(input logic [DW-1:0] v);
    return {{EXT_W{v[DW-1]}}, v};
  endfunction

  cap_state_e         state;
  cap_state_e         state_nxt;
  logic [DW-1:0]      s_i;
  logic [DW-1:0]      s_q;
  logic               s_v;
  logic [SCNT_W-1:0]  sample_cnt;
  logic [SCNT_W-1:0]  sample_cnt_nxt;
  logic [CNT_W-1:0]   frame_cnt_nxt;
  logic [CNT_W-1:0]   drop_cnt_nxt;
  logic               overflow_nxt;
  logic               wr_en_c;
  cap_word_t          wr_word_c;
  cap_word_t          rd_word;
  logic               fifo_full;
  logic               fifo_empty;

  always_ff @(posedge adc_clk100m) begin
    if (ad_rst) begin
      s_i <= '0;
      s_q <= '0;
      s_v <= 1'b0;
    end else begin
      s_i <= dc_sub(ad_data_i, dc_off_i);
      s_q <= dc_sub(ad_data_q, dc_off_q);
      s_v <= ad_data_valid;
    end
  end

  always_ff @(posedge adc_clk100m) begin
    if (ad_rst) begin
      state      <= ST_IDLE;
      sample_cnt <= '0;
      frame_cnt  <= '0;
      drop_cnt   <= '0;
      overflow   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      sample_cnt <= sample_cnt_nxt;
      frame_cnt  <= frame_cnt_nxt;
      drop_cnt   <= drop_cnt_nxt;
      overflow   <= overflow_nxt;
      busy       <= (state_nxt != ST_IDLE);
    end
  end

  // cont_en is only consulted at frame end, so clearing it mid-frame finishes that frame
  always_comb begin
    state_nxt      = state;
    sample_cnt_nxt = sample_cnt;
    frame_cnt_nxt  = frame_cnt;
    drop_cnt_nxt   = drop_cnt;
    overflow_nxt   = overflow;
    wr_en_c        = 1'b0;
    wr_word_c      = '0;
    case (state)
      ST_IDLE: begin
        if (cap_start || cont_en) state_nxt = ST_HDR;
      end
      ST_HDR: begin
        if (!fifo_full) begin
          wr_en_c        = 1'b1;
          wr_word_c.data = {HDR_MAGIC, frame_cnt};
          state_nxt      = ST_DATA;
        end
      end
      ST_DATA: begin
        if (s_v) begin
          if (!fifo_full) begin
            wr_en_c        = 1'b1;
            wr_word_c.data = {sext16(s_i), sext16(s_q)};
            if (sample_cnt == LAST_IDX) begin
              wr_word_c.last = 1'b1;
              frame_cnt_nxt  = frame_cnt + CNT_W'(1);
              sample_cnt_nxt = '0;
              state_nxt      = cont_en ? ST_HDR : ST_IDLE;
            end else begin
              sample_cnt_nxt = sample_cnt + SCNT_W'(1);
            end
          end else begin
            overflow_nxt = 1'b1;
            if (drop_cnt != '1) drop_cnt_nxt = drop_cnt + CNT_W'(1);
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  ad_cap_sync_fifo #(
    .WIDTH (CAP_WORD_W),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk     (adc_clk100m),
    .rst     (ad_rst),
    .wr_en   (wr_en_c),
    .wr_data (wr_word_c),
    .rd_en   (m_ready),
    .rd_data (rd_word),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Memory contents are not reset, so the head word is masked while nothing is queued
  assign m_valid = ~fifo_empty;
  assign m_data  = m_valid ? rd_word.data : '0;
  assign m_last  = m_valid & rd_word.last;

endmodule

// File: tb/tb_ad_iq_frame_packer.sv
// Randomized self-checking bench for ad_iq_frame_packer with a queue-based
// behavioural reference of the capture/framing rules.
module tb_ad_iq_frame_packer;

  localparam int unsigned DW    = 14;
  localparam int unsigned FL    = 4;
  localparam int unsigned AW    = 2;
  localparam int unsigned DEPTH = 4;

  logic          adc_clk100m = 1'b0;
  logic          ad_rst = 1'b1;
  logic [DW-1:0] ad_data_i = '0;
  logic [DW-1:0] ad_data_q = '0;
  logic          ad_data_valid = 1'b0;
  logic [DW-1:0] dc_off_i = '0;
  logic [DW-1:0] dc_off_q = '0;
  logic          cap_start = 1'b0;
  logic          cont_en = 1'b0;
  logic          m_ready = 1'b0;
  logic [31:0]   m_data;
  logic          m_valid;
  logic          m_last;
  logic          busy;
  logic          overflow;
  logic [15:0]   drop_cnt;
  logic [15:0]   frame_cnt;

  ad_iq_frame_packer #(
    .DW        (DW),
    .FRAME_LEN (FL),
    .FIFO_AW   (AW),
    .HDR_MAGIC (16'hA55A)
  ) dut (
    .adc_clk100m   (adc_clk100m),
    .ad_rst        (ad_rst),
    .ad_data_i     (ad_data_i),
    .ad_data_q     (ad_data_q),
    .ad_data_valid (ad_data_valid),
    .dc_off_i      (dc_off_i),
    .dc_off_q      (dc_off_q),
    .cap_start     (cap_start),
    .cont_en       (cont_en),
    .m_data        (m_data),
    .m_valid       (m_valid),
    .m_last        (m_last),
    .m_ready       (m_ready),
    .busy          (busy),
    .overflow      (overflow),
    .drop_cnt      (drop_cnt),
    .frame_cnt     (frame_cnt)
  );

  always #5 adc_clk100m = ~adc_clk100m;

  int total = 0;
  int bad   = 0;

  // Reference: mode 0 idle, 1 waiting to emit header, 2 collecting samples
  int   md_mode  = 0;
  int   md_scnt  = 0;
  int   md_fcnt  = 0;
  int   md_drops = 0;
  bit   md_ovf   = 0;
  bit   md_sv    = 0;
  int   md_si    = 0;
  int   md_sq    = 0;
  logic [32:0] md_fifo[$];
  logic [32:0] exp_out[$];
  logic [32:0] got[$];

  function automatic int sat_ref(int v);
    if (v > 8191)  return 8191;
    if (v < -8192) return -8192;
    return v;
  endfunction

  function automatic logic [32:0] mk_word(bit last, int hi, int lo);
    return {last, 16'(hi), 16'(lo)};
  endfunction

  always @(posedge adc_clk100m) begin : ref_model
    bit full;
    bit last_w;
    if (ad_rst) begin
      md_mode = 0; md_scnt = 0; md_fcnt = 0; md_drops = 0; md_ovf = 0;
      md_sv = 0; md_si = 0; md_sq = 0;
      md_fifo.delete();
    end else begin
      full = (md_fifo.size() == DEPTH);
      if (md_fifo.size() > 0 && m_ready) exp_out.push_back(md_fifo.pop_front());
      case (md_mode)
        0: if (cap_start || cont_en) md_mode = 1;
        1: if (!full) begin
             md_fifo.push_back(mk_word(1'b0, 16'hA55A, md_fcnt));
             md_mode = 2;
           end
        default: if (md_sv) begin
             if (!full) begin
               last_w = (md_scnt == FL - 1);
               md_fifo.push_back(mk_word(last_w, md_si, md_sq));
               if (last_w) begin
                 md_fcnt = (md_fcnt + 1) % 65536;
                 md_scnt = 0;
                 md_mode = cont_en ? 1 : 0;
               end else begin
                 md_scnt++;
               end
             end else begin
               if (md_drops < 65535) md_drops++;
               md_ovf = 1;
             end
           end
      endcase
      md_sv = ad_data_valid;
      md_si = sat_ref(int'($signed(ad_data_i)) - int'($signed(dc_off_i)));
      md_sq = sat_ref(int'($signed(ad_data_q)) - int'($signed(dc_off_q)));
    end
  end

  always @(posedge adc_clk100m) begin
    if (!ad_rst && m_valid && m_ready) got.push_back({m_last, m_data});
  end

  task automatic rand_sample(bit v);
    ad_data_valid = v;
    ad_data_i     = DW'($urandom);
    ad_data_q     = DW'($urandom);
  endtask

  task automatic reset_dut();
    @(negedge adc_clk100m);
    ad_rst = 1'b1; cap_start = 1'b0; cont_en = 1'b0; ad_data_valid = 1'b0; m_ready = 1'b0;
    repeat (2) @(negedge adc_clk100m);
    ad_rst = 1'b0;
    got.delete();
    exp_out.delete();
  endtask

  // Feed samples with the sink always ready until the reference is idle and empty
  task automatic drain(output bit ok);
    ok = 1'b0;
    cap_start = 1'b0; cont_en = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge adc_clk100m);
      if (md_mode == 0 && md_fifo.size() == 0) begin
        ok = 1'b1;
        break;
      end
      rand_sample($urandom_range(0, 3) != 0);
    end
    ad_data_valid = 1'b0;
    @(negedge adc_clk100m);
  endtask

  task automatic test_reset();
    @(negedge adc_clk100m);
    ad_rst = 1'b0; m_ready = 1'b0; cap_start = 1'b1;
    @(negedge adc_clk100m);
    cap_start = 1'b0;
    repeat (4) begin
      @(negedge adc_clk100m);
      rand_sample(1'b1);
    end
    ad_rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge adc_clk100m);
      total++;
      if ({m_valid, m_last, busy, overflow} !== 4'b0000) begin
        bad++;
        $display("FAIL reset_flags cyc=%0d got v/l/busy/ovf=%b required 0000", i, {m_valid, m_last, busy, overflow});
      end
      total++;
      if ({m_data, drop_cnt, frame_cnt} !== 64'd0) begin
        bad++;
        $display("FAIL reset_values cyc=%0d got data=%h drop=%0d frame=%0d required 0", i, m_data, drop_cnt, frame_cnt);
      end
      rand_sample($urandom_range(0, 1));
      cap_start = 1'($urandom_range(0, 1));
      cont_en   = 1'($urandom_range(0, 1));
      m_ready   = 1'($urandom_range(0, 1));
    end
    cap_start = 1'b0; cont_en = 1'b0; ad_data_valid = 1'b0; m_ready = 1'b0;
    ad_rst = 1'b0;
    got.delete();
    exp_out.delete();
  endtask

  task automatic test_dc_sat();
    int          vi[3] = '{8191, -8192, 100};
    int          vq[3] = '{0, 0, -3};
    int          oi[3] = '{-10, 5, 40};
    logic [31:0] ew[3] = '{32'h1FFF_0000, 32'hE000_0000, 32'h003C_FFFD};
    bit          ok;
    reset_dut();
    m_ready = 1'b1; dc_off_q = '0;
    cap_start = 1'b1;
    @(negedge adc_clk100m);
    cap_start = 1'b0;
    @(negedge adc_clk100m);
    for (int k = 0; k < 3; k++) begin
      @(negedge adc_clk100m);
      ad_data_i = DW'(vi[k]); ad_data_q = DW'(vq[k]); dc_off_i = DW'(oi[k]);
      ad_data_valid = 1'b1;
      @(negedge adc_clk100m);
      ad_data_valid = 1'b0;
      total++;
      if (m_valid !== 1'b0) begin
        bad++;
        $display("FAIL dc_latency_early k=%0d got m_valid=%b required 0", k, m_valid);
      end
      @(negedge adc_clk100m);
      total++;
      if ({m_valid, m_last, m_data} !== {2'b10, ew[k]}) begin
        bad++;
        $display("FAIL dc_sat k=%0d got v=%b l=%b data=%h required v=1 l=0 data=%h", k, m_valid, m_last, m_data, ew[k]);
      end
    end
    dc_off_i = DW'($urandom); dc_off_q = DW'($urandom);
    drain(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL dc_drain_timeout got busy=%b required idle", busy); end
    total++;
    if (got.size() !== exp_out.size()) begin
      bad++;
      $display("FAIL dc_count got %0d words required %0d", got.size(), exp_out.size());
    end
    for (int i = 0; i < got.size() && i < exp_out.size(); i++) begin
      total++;
      if (got[i] !== exp_out[i]) begin
        bad++;
        $display("FAIL dc_word[%0d] got %h required %h", i, got[i], exp_out[i]);
        break;
      end
    end
  endtask

  task automatic test_single_frame();
    reset_dut();
    dc_off_i = DW'($urandom_range(0, 200)); dc_off_q = DW'(-$urandom_range(0, 200));
    m_ready = 1'b1; cap_start = 1'b1;
    @(negedge adc_clk100m);
    cap_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      rand_sample(1'b1);
      @(negedge adc_clk100m);
    end
    ad_data_valid = 1'b0;
    repeat (6) @(negedge adc_clk100m);
    total++;
    if (got.size() !== 5) begin
      bad++;
      $display("FAIL frame_len got %0d words required 5", got.size());
    end else begin
      total++;
      if (got[0] !== 33'h0_A55A_0000) begin
        bad++;
        $display("FAIL frame_header got %h required 0a55a0000", got[0]);
      end
      total++;
      if ({got[1][32], got[2][32], got[3][32], got[4][32]} !== 4'b0001) begin
        bad++;
        $display("FAIL frame_last got %b required 0001", {got[1][32], got[2][32], got[3][32], got[4][32]});
      end
    end
    total++;
    if ({busy, frame_cnt} !== {1'b0, 16'd1}) begin
      bad++;
      $display("FAIL frame_status got busy=%b frame_cnt=%0d required busy=0 frame_cnt=1", busy, frame_cnt);
    end
    total++;
    if (got.size() !== exp_out.size()) begin
      bad++;
      $display("FAIL frame_model_count got %0d required %0d", got.size(), exp_out.size());
    end
    for (int i = 0; i < got.size() && i < exp_out.size(); i++) begin
      total++;
      if (got[i] !== exp_out[i]) begin
        bad++;
        $display("FAIL frame_word[%0d] got %h required %h", i, got[i], exp_out[i]);
        break;
      end
    end
  endtask

  task automatic test_back_to_back();
    bit dropped = 1'b0;
    bit ok;
    reset_dut();
    m_ready = 1'b1; cont_en = 1'b1;
    for (int i = 0; i < 300 && !dropped; i++) begin
      @(negedge adc_clk100m);
      rand_sample(1'b1);
      if (md_fcnt == 2 && md_mode == 2 && md_scnt >= 1) begin
        cont_en = 1'b0;
        dropped = 1'b1;
      end
    end
    total++;
    if (!dropped) begin bad++; $display("FAIL b2b_timeout got frame_cnt=%0d required to reach frame 3", frame_cnt); end
    drain(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL b2b_drain_timeout got busy=%b required idle", busy); end
    total++;
    if (got.size() !== 15) begin
      bad++;
      $display("FAIL b2b_len got %0d words required 15", got.size());
    end else begin
      for (int f = 0; f < 3; f++) begin
        total++;
        if (got[5*f] !== mk_word(1'b0, 16'hA55A, f)) begin
          bad++;
          $display("FAIL b2b_header[%0d] got %h required %h", f, got[5*f], mk_word(1'b0, 16'hA55A, f));
        end
      end
    end
    total++;
    if ({busy, frame_cnt} !== {1'b0, 16'd3}) begin
      bad++;
      $display("FAIL b2b_status got busy=%b frame_cnt=%0d required busy=0 frame_cnt=3", busy, frame_cnt);
    end
    total++;
    if (got.size() !== exp_out.size()) begin
      bad++;
      $display("FAIL b2b_model_count got %0d required %0d", got.size(), exp_out.size());
    end
    for (int i = 0; i < got.size() && i < exp_out.size(); i++) begin
      total++;
      if (got[i] !== exp_out[i]) begin
        bad++;
        $display("FAIL b2b_word[%0d] got %h required %h", i, got[i], exp_out[i]);
        break;
      end
    end
  endtask

  task automatic test_overflow();
    bit          hold;
    logic [32:0] held;
    bit          done = 1'b0;
    int          serr = 0;
    int          nd;
    reset_dut();
    m_ready = 1'b0; cont_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge adc_clk100m);
      if (m_valid) begin
        total++;
        if ({m_last, m_data} !== 33'h0_A55A_0000) begin
          bad++;
          $display("FAIL ovf_stall_head cyc=%0d got %h required 0a55a0000", i, {m_last, m_data});
        end
      end
      rand_sample(1'b1);
    end
    @(negedge adc_clk100m);
    ad_data_valid = 1'b0;
    @(negedge adc_clk100m);
    total++;
    if ({overflow, drop_cnt} !== {1'b1, 16'd9}) begin
      bad++;
      $display("FAIL ovf_drops got overflow=%b drop_cnt=%0d required overflow=1 drop_cnt=9", overflow, drop_cnt);
    end
    hold = 1'b0;
    held = '0;
    for (int i = 0; i < 500; i++) begin
      if (hold) begin
        total++;
        if ({m_valid, m_last, m_data} !== {1'b1, held}) begin
          bad++;
          $display("FAIL ovf_hold cyc=%0d got v=%b word=%h required v=1 word=%h", i, m_valid, {m_last, m_data}, held);
        end
      end
      if (i > 40 && md_mode == 0 && md_fifo.size() == 0) begin
        done = 1'b1;
        break;
      end
      if (i == 40) cont_en = 1'b0;
      m_ready = 1'($urandom_range(0, 1));
      rand_sample($urandom_range(0, 3) != 0);
      hold = m_valid & ~m_ready;
      held = {m_last, m_data};
      @(negedge adc_clk100m);
    end
    ad_data_valid = 1'b0;
    total++;
    if (!done) begin bad++; $display("FAIL ovf_release_timeout got busy=%b required idle", busy); end
    nd = got.size() / (FL + 1);
    for (int f = 0; f < nd; f++) begin
      if (got[f*(FL+1)][32:16] !== 17'h0A55A) serr++;
      for (int j = 1; j <= FL; j++) begin
        if (got[f*(FL+1)+j][32] !== 1'(j == FL)) serr++;
      end
    end
    total++;
    if ((got.size() % (FL + 1)) != 0 || serr != 0) begin
      bad++;
      $display("FAIL ovf_framing got %0d words with %0d layout errors required whole frames of %0d data words", got.size(), serr, FL);
    end
    total++;
    if ({overflow, drop_cnt, frame_cnt} !== {md_ovf, 16'(md_drops), 16'(md_fcnt)}) begin
      bad++;
      $display("FAIL ovf_counters got ovf=%b drop=%0d frame=%0d required ovf=%b drop=%0d frame=%0d", overflow, drop_cnt, frame_cnt, md_ovf, md_drops, md_fcnt);
    end
    total++;
    if (got.size() !== exp_out.size()) begin
      bad++;
      $display("FAIL ovf_model_count got %0d required %0d", got.size(), exp_out.size());
    end
    for (int i = 0; i < got.size() && i < exp_out.size(); i++) begin
      total++;
      if (got[i] !== exp_out[i]) begin
        bad++;
        $display("FAIL ovf_word[%0d] got %h required %h", i, got[i], exp_out[i]);
        break;
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    reset_dut();
    m_ready = 1'b0; cap_start = 1'b1;
    @(negedge adc_clk100m);
    cap_start = 1'b0;
    repeat (4) begin
      rand_sample(1'b1);
      @(negedge adc_clk100m);
    end
    total++;
    if ({m_valid, busy} !== 2'b11) begin
      bad++;
      $display("FAIL midrst_pre got v=%b busy=%b required 11", m_valid, busy);
    end
    ad_rst = 1'b1;
    @(negedge adc_clk100m);
    total++;
    if ({m_valid, m_last, busy, frame_cnt, drop_cnt} !== 35'd0) begin
      bad++;
      $display("FAIL midrst_clear got v=%b l=%b busy=%b frame=%0d drop=%0d required all 0", m_valid, m_last, busy, frame_cnt, drop_cnt);
    end
    ad_rst = 1'b0; ad_data_valid = 1'b0;
    got.delete();
    exp_out.delete();
    cap_start = 1'b1;
    @(negedge adc_clk100m);
    cap_start = 1'b0;
    drain(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL midrst_drain_timeout got busy=%b required idle", busy); end
    total++;
    if (got.size() !== 5) begin
      bad++;
      $display("FAIL midrst_len got %0d words required 5", got.size());
    end else begin
      total++;
      if (got[0] !== 33'h0_A55A_0000) begin
        bad++;
        $display("FAIL midrst_header got %h required 0a55a0000", got[0]);
      end
    end
    for (int i = 0; i < got.size() && i < exp_out.size(); i++) begin
      total++;
      if (got[i] !== exp_out[i]) begin
        bad++;
        $display("FAIL midrst_word[%0d] got %h required %h", i, got[i], exp_out[i]);
        break;
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    reset_dut();
    for (int i = 0; i < 800; i++) begin
      @(negedge adc_clk100m);
      if (i % 100 == 0) begin
        dc_off_i = DW'($urandom); dc_off_q = DW'($urandom);
      end
      rand_sample($urandom_range(0, 9) < 7);
      m_ready   = ($urandom_range(0, 9) < 6);
      cap_start = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 49) == 0) cont_en = ~cont_en;
      if ((i % 50) == 49) begin
        total++;
        if ({busy, overflow, drop_cnt, frame_cnt} !== {md_mode != 0, md_ovf, 16'(md_drops), 16'(md_fcnt)}) begin
          bad++;
          $display("FAIL rand_status cyc=%0d got busy=%b ovf=%b drop=%0d frame=%0d required busy=%b ovf=%b drop=%0d frame=%0d",
                   i, busy, overflow, drop_cnt, frame_cnt, md_mode != 0, md_ovf, md_drops, md_fcnt);
        end
      end
    end
    drain(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL rand_drain_timeout got busy=%b required idle", busy); end
    total++;
    if (got.size() !== exp_out.size()) begin
      bad++;
      $display("FAIL rand_count got %0d required %0d", got.size(), exp_out.size());
    end
    for (int i = 0; i < got.size() && i < exp_out.size(); i++) begin
      total++;
      if (got[i] !== exp_out[i]) begin
        bad++;
        $display("FAIL rand_word[%0d] got %h required %h", i, got[i], exp_out[i]);
        break;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got no completion required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_dc_sat();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_reset_mid_frame();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
